mac_operand_arb: RTL

MAC_OPERAND_ARB -- requirements
Module: mac_operand_arb

---
 rtl/mac_pkg.sv | 11 +
 rtl/mac_rr_pick.sv | 38 +++
 rtl/mac_operand_arb.sv | 107 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared MAC definitions: arbitration mode encodings and the channel-index width helper.
package mac_pkg;

  localparam int ARB_FIXED = 32'sd0;
  localparam int ARB_RR    = 32'sd1;

  function automatic int chan_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/mac_rr_pick.sv
// One-hot grant picker: fixed priority from channel 0, or a wrapping scan
// starting at the round-robin pointer.
module mac_rr_pick
  import mac_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MODE     = ARB_FIXED,
  parameter int CW       = chan_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       start,
  output logic [CHANNELS-1:0] gnt
);

  logic [CW-1:0] idx_s;
  logic          found_s;

  // Walk the candidates in priority order and grant the first requester.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 32'sd0; i < CHANNELS; i++) begin
      if (MODE == ARB_RR) begin
        idx_s = CW'((int'(start) + i) % CHANNELS);
      end else begin
        idx_s = CW'(i);
      end
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mac_operand_arb.sv
// Operand arbiter: picks one of CHANNELS valid/ready inputs and registers the
// selected operand and its channel index into a single output beat.
module mac_operand_arb
  import mac_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = ARB_FIXED,
  parameter int CW       = chan_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      lock,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [CW-1:0]       rr_ptr_r;
  logic [CW-1:0]       last_chan_r;
  logic                load_en_s;
  logic                lock_hit_s;
  logic [CHANNELS-1:0] req_s;
  logic [CHANNELS-1:0] gnt_s;
  logic [CW-1:0]       sel_chan_s;
  logic [WIDTH-1:0]    sel_data_s;
  logic                xfer_s;
  logic [CW-1:0]       next_ptr_s;

  // A held lock narrows the request set to the last accepted channel.
  always_comb begin
    lock_hit_s = lock && in_valid[last_chan_r];
    req_s      = in_valid;
    if (lock_hit_s) begin
      req_s              = '0;
      req_s[last_chan_r] = 1'b1;
    end else begin
      req_s = in_valid;
    end
  end

  mac_rr_pick #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE),
    .CW       (CW)
  ) u_pick (
    .req   (req_s),
    .start (rr_ptr_r),
    .gnt   (gnt_s)
  );

  assign load_en_s = !out_valid || out_ready;

  // Grants are only exposed when the output register can take the beat.
  always_comb begin
    if (load_en_s && rst_n) begin
      in_ready = gnt_s;
    end else begin
      in_ready = '0;
    end
  end

  assign xfer_s = |in_ready;

  // The grant is one-hot, so OR-ing masked slices yields the selected operand.
  always_comb begin
    sel_chan_s = '0;
    sel_data_s = '0;
    for (int i = 32'sd0; i < CHANNELS; i++) begin
      sel_chan_s = sel_chan_s | (CW'(i) & {CW{gnt_s[i]}});
      sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_s[i]}});
    end
  end

  // Pointer moves one past the accepted channel, wrapping at the top.
  always_comb begin
    if (sel_chan_s == CW'(CHANNELS - 32'sd1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = sel_chan_s + CW'(1'b1);
    end
  end

  // Output beat, arbitration pointer and lock history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_chan    <= '0;
      rr_ptr_r    <= '0;
      last_chan_r <= '0;
    end else if (xfer_s) begin
      out_valid   <= 1'b1;
      out_data    <= sel_data_s;
      out_chan    <= sel_chan_s;
      rr_ptr_r    <= next_ptr_s;
      last_chan_r <= sel_chan_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
